// File: rtl/writeback_arbiter_if.sv
// Result-writeback bundle between the RS/LSB producers, the arbiter and the ROB submit port.
// master = producers + ROB side, slave = writeback_arbiter.
interface writeback_arbiter_if #(
  parameter int TAG_W = 4,
  parameter int VAL_W = 32
);
  logic [TAG_W-1:0] rs_tag;
  logic [VAL_W-1:0] rs_val;
  logic             rs_valid;
  logic             rs_ready;

  logic [TAG_W-1:0] lsb_tag;
  logic [VAL_W-1:0] lsb_val;
  logic             lsb_valid;
  logic             lsb_ready;

  logic [TAG_W-1:0] out_tag;
  logic [VAL_W-1:0] out_val;
  logic             out_valid;
  logic             out_ready;
  logic             out_src;

  modport master (
    output rs_tag, rs_val, rs_valid, lsb_tag, lsb_val, lsb_valid, out_ready,
    input  rs_ready, lsb_ready, out_tag, out_val, out_valid, out_src
  );

  modport slave (
    input  rs_tag, rs_val, rs_valid, lsb_tag, lsb_val, lsb_valid, out_ready,
    output rs_ready, lsb_ready, out_tag, out_val, out_valid, out_src
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Two small result FIFOs (RS, LSB) sharing one ROB writeback port, round-robin arbitrated.
// Define WB_ARB_FIXED_PRIO_EN to give the LSB strict priority on ties instead.
module writeback_arbiter #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int VAL_W = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                predict_fail,
  writeback_arbiter_if.slave  wb
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + VAL_W;

  typedef enum logic {
    SRC_RS  = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  logic [ENT_W-1:0] mem   [2][DEPTH];
  logic [PTR_W-1:0] head  [2];
  logic [PTR_W-1:0] tail  [2];
  logic [CNT_W-1:0] count [2];

  logic [ENT_W-1:0] push_ent [2];
  logic [1:0]       ready;
  logic [1:0]       req;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [ENT_W-1:0] head_ent;
  logic             any_req;
  logic             out_valid;
  logic             out_fire;
  logic             flush;
  src_e             grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Per-side handshake: ready looks only at occupancy, so a full FIFO refuses
  // a push even in the cycle it is being popped.
  always_comb begin
    push_ent[0] = {wb.rs_tag, wb.rs_val};
    push_ent[1] = {wb.lsb_tag, wb.lsb_val};
    ready = '0;
    req   = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      ready[s] = rdy_in && (count[s] != CNT_W'(DEPTH));
      req[s]   = (count[s] != '0);
    end
    push[0] = wb.rs_valid  && ready[0] && !predict_fail;
    push[1] = wb.lsb_valid && ready[1] && !predict_fail;
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = req[1] ? SRC_LSB : SRC_RS;
  end
`else
  src_e last_grant;

  always_comb begin
    grant = SRC_RS;
    if (req[0] && req[1]) begin
      grant = (last_grant == SRC_LSB) ? SRC_RS : SRC_LSB;
    end else if (req[1]) begin
      grant = SRC_LSB;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= SRC_LSB;
    end else if (rdy_in) begin
      if (predict_fail) begin
        last_grant <= SRC_LSB;
      end else if (out_fire) begin
        last_grant <= grant;
      end
    end
  end
`endif

  always_comb begin
    any_req   = req[0] || req[1];
    out_valid = rdy_in && !predict_fail && any_req;
    out_fire  = out_valid && wb.out_ready;
    flush     = rdy_in && predict_fail;
    pop[0]    = out_fire && (grant == SRC_RS);
    pop[1]    = out_fire && (grant == SRC_LSB);
    head_ent  = mem[grant][head[grant]];
  end

  always_comb begin
    wb.rs_ready  = ready[0];
    wb.lsb_ready = ready[1];
    wb.out_valid = out_valid;
    wb.out_tag   = '0;
    wb.out_val   = '0;
    wb.out_src   = 1'b0;
    if (out_valid) begin
      wb.out_tag = head_ent[ENT_W-1:VAL_W];
      wb.out_val = head_ent[VAL_W-1:0];
      wb.out_src = (grant == SRC_LSB);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
    end else if (flush) begin
      for (int unsigned s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
    end else if (rdy_in) begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (push[s]) tail[s] <= ptr_inc(tail[s]);
        if (pop[s])  head[s] <= ptr_inc(head[s]);
        if (push[s] && !pop[s]) begin
          count[s] <= count[s] + CNT_W'(1);
        end else if (pop[s] && !push[s]) begin
          count[s] <= count[s] - CNT_W'(1);
        end
      end
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_in) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (push[s]) mem[s][tail[s]] <= push_ent[s];
    end
  end

  a_rs_count_bound: assert property (@(posedge clk_in) disable iff (rst_in)
    count[0] <= CNT_W'(DEPTH));
  a_lsb_count_bound: assert property (@(posedge clk_in) disable iff (rst_in)
    count[1] <= CNT_W'(DEPTH));
  a_no_valid_when_paused: assert property (@(posedge clk_in) disable iff (rst_in)
    !rdy_in |-> !wb.out_valid);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_arbiter;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int VAL_W = 32;
`ifdef WB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef logic [TAG_W+VAL_W-1:0] ent_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic predict_fail;

  always #5 clk_in = ~clk_in;

  writeback_arbiter_if #(.TAG_W(TAG_W), .VAL_W(VAL_W)) wb ();

  writeback_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .VAL_W(VAL_W)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .predict_fail(predict_fail),
    .wb          (wb.slave)
  );

  // reference model: one queue per requester plus the side that last won
  ent_t             rs_q[$];
  ent_t             lsb_q[$];
  bit               last_lsb;
  logic [TAG_W-1:0] dut_log[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    rs_q.delete();
    lsb_q.delete();
    last_lsb = 1'b1;
  endtask

  task automatic drive(input bit rdy, input bit pf,
                       input bit rv, input logic [TAG_W-1:0] rt, input logic [VAL_W-1:0] rval,
                       input bit lv, input logic [TAG_W-1:0] lt, input logic [VAL_W-1:0] lval,
                       input bit ordy);
    rdy_in       = rdy;
    predict_fail = pf;
    wb.rs_valid  = rv;
    wb.rs_tag    = rt;
    wb.rs_val    = rval;
    wb.lsb_valid = lv;
    wb.lsb_tag   = lt;
    wb.lsb_val   = lval;
    wb.out_ready = ordy;
  endtask

  // one clock cycle: drive at negedge, check outputs, advance the model
  task automatic step(input bit rdy, input bit pf,
                      input bit rv, input logic [TAG_W-1:0] rt, input logic [VAL_W-1:0] rval,
                      input bit lv, input logic [TAG_W-1:0] lt, input logic [VAL_W-1:0] lval,
                      input bit ordy);
    bit   er, el, ev, g_lsb;
    ent_t ent;
    @(negedge clk_in);
    drive(rdy, pf, rv, rt, rval, lv, lt, lval, ordy);
    #1;
    er = rdy && (rs_q.size() != DEPTH);
    el = rdy && (lsb_q.size() != DEPTH);
    ev = rdy && !pf && (rs_q.size() != 0 || lsb_q.size() != 0);
    if (rs_q.size() == 0)       g_lsb = 1'b1;
    else if (lsb_q.size() == 0) g_lsb = 1'b0;
    else                        g_lsb = FIXED ? 1'b1 : !last_lsb;
    ent = '0;
    if (ev) ent = g_lsb ? lsb_q[0] : rs_q[0];
    check("rs_ready",  wb.rs_ready,  er);
    check("lsb_ready", wb.lsb_ready, el);
    check("out_valid", wb.out_valid, ev);
    check("out_tag",   wb.out_tag,   ent[TAG_W+VAL_W-1:VAL_W]);
    check("out_val",   wb.out_val,   ent[VAL_W-1:0]);
    check("out_src",   wb.out_src,   ev && g_lsb);
    if (wb.out_valid && ordy) dut_log.push_back(wb.out_tag);
    if (rdy) begin
      if (pf) begin
        model_clear();
      end else begin
        if (ev && ordy) begin
          if (g_lsb) void'(lsb_q.pop_front());
          else       void'(rs_q.pop_front());
          last_lsb = g_lsb;
        end
        if (rv && er) rs_q.push_back({rt, rval});
        if (lv && el) lsb_q.push_back({lt, lval});
      end
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ordy);
  endtask

  // reset asserted between clock edges must take effect immediately
  task automatic mid_reset();
    @(negedge clk_in);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    model_clear();
    check("rst_out_valid", wb.out_valid, 1'b0);
    check("rst_out_tag",   wb.out_tag,   '0);
    check("rst_rs_ready",  wb.rs_ready,  1'b1);
    check("rst_lsb_ready", wb.lsb_ready, 1'b1);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic check_log(input string tag, input int n, input logic [TAG_W-1:0] e0,
                           input logic [TAG_W-1:0] e1, input logic [TAG_W-1:0] e2,
                           input logic [TAG_W-1:0] e3);
    logic [TAG_W-1:0] exp_tags [4];
    exp_tags = '{e0, e1, e2, e3};
    check({tag, "_len"}, dut_log.size(), n);
    for (int i = 0; i < n && i < dut_log.size(); i++)
      check({tag, "_order"}, dut_log[i], exp_tags[i]);
  endtask

  initial begin
    rst_in = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    model_clear();
    #1;
    check("reset_out_valid", wb.out_valid, 1'b0);
    check("reset_out_src",   wb.out_src,   1'b0);
    check("reset_out_val",   wb.out_val,   '0);
    check("reset_rs_ready",  wb.rs_ready,  1'b1);
    @(negedge clk_in);
    rst_in = 1'b0;

    // single push
    step(1'b1, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1);
    dut_log.delete();
    idle(1'b1);
    idle(1'b1);
    check_log("single", 1, 4'd3, 0, 0, 0);

    // round-robin vs fixed priority ordering
    mid_reset();
    step(1'b1, 1'b0, 1'b1, 4'd1, 32'h11, 1'b1, 4'd5, 32'h55, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd2, 32'h22, 1'b1, 4'd6, 32'h66, 1'b0);
    dut_log.delete();
    repeat (5) idle(1'b1);
    if (FIXED) check_log("rr", 4, 4'd5, 4'd6, 4'd1, 4'd2);
    else       check_log("rr", 4, 4'd1, 4'd5, 4'd2, 4'd6);

    // full FIFO and backpressure
    step(1'b1, 1'b0, 1'b1, 4'd1, 32'hA1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd2, 32'hA2, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd3, 32'hA3, 1'b0, '0, '0, 1'b0);
    dut_log.delete();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(1'b0);
    repeat (3) idle(1'b1);
    check_log("full", 2, 4'd1, 4'd2, 0, 0);

    // flush discards buffered entries and the same-cycle push
    step(1'b1, 1'b0, 1'b1, 4'd1, 32'hB1, 1'b1, 4'd4, 32'hB4, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd2, 32'hB2, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 4'd7, 32'hB7, 1'b1);
    dut_log.delete();
    repeat (3) idle(1'b1);
    check("flush_drain_len", dut_log.size(), 0);

    // pause freezes everything
    step(1'b1, 1'b0, 1'b1, 4'd1, 32'hC1, 1'b1, 4'd9, 32'hC9, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd2, 32'hC2, 1'b0, '0, '0, 1'b0);
    dut_log.delete();
    repeat (3) step(1'b0, 1'b0, 1'b1, 4'd14, 32'hEE, 1'b1, 4'd15, 32'hFF, 1'b1);
    check("pause_pop_len", dut_log.size(), 0);
    repeat (4) idle(1'b1);
    if (FIXED) check_log("pause", 3, 4'd9, 4'd1, 4'd2, 0);
    else       check_log("pause", 3, 4'd1, 4'd9, 4'd2, 0);

    // pointer wrap through the RS FIFO
    mid_reset();
    dut_log.delete();
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b1, TAG_W'(i), $urandom(), 1'b0, '0, '0, 1'b1);
    repeat (2) idle(1'b1);
    check("wrap_len", dut_log.size(), 5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++)
      check("wrap_order", dut_log[i], TAG_W'(i));
    step(1'b1, 1'b0, 1'b1, 4'd8, 32'h88, 1'b0, '0, '0, 1'b0);
    mid_reset();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) mid_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, TAG_W'($urandom_range(0, 15)), $urandom(),
           $urandom_range(0, 2) != 0, TAG_W'($urandom_range(0, 15)), $urandom(),
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the reorder buffer's single result-writeback port between the reservation station (RS) and the load/store buffer (LSB). Each requester pushes a {tag, value} result into its own small FIFO. One entry per cycle is forwarded to the ROB under round-robin arbitration. Everything is flushed on a branch misprediction, and all state freezes while `rdy_in` is low.

## Interface
Parameters:
- `DEPTH`, default 2: entries per requester FIFO; power of two, ≥2.
- `TAG_W`, default 4: ROB tag width.
- `VAL_W`, default 32: result value width.

Ports:
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, asynchronous and active-high.
- `rdy_in` input 1: global pause, active low.
- `predict_fail` input 1: flush request from the branch predictor.
- `rs_tag` input TAG_W: RS result tag.
- `rs_val` input VAL_W: RS result value.
- `rs_valid` input 1: RS push request.
- `rs_ready` output 1: RS FIFO accepts a push this cycle.
- `lsb_tag` input TAG_W: LSB result tag.
- `lsb_val` input VAL_W: LSB result value.
- `lsb_valid` input 1: LSB push request.
- `lsb_ready` output 1: LSB FIFO accepts a push this cycle.
- `out_tag` output TAG_W: granted entry's tag, to the ROB submit port.
- `out_val` output VAL_W: granted entry's value.
- `out_valid` output 1: a result is presented to the ROB.
- `out_ready` input 1: ROB consumes the presented result.
- `out_src` output 1: source of the presented result; 0 = RS, 1 = LSB.

## Operation
- **FIFO storage.** Each FIFO is circular, with `head`, `tail` and `count` (width log2(DEPTH)+1).
  - Pointers wrap from DEPTH-1 to 0.
  - Entries are {tag, val}.
- **Push.** `x_ready = rdy_in && (count_x != DEPTH)`.
  - A push occurs on a clock edge when `x_valid && x_ready && !predict_fail`.
  - `x_ready` depends only on `count`. A full FIFO refuses a push even in a cycle where it is also popped.
- **Request.** `req_rs = (count_rs != 0)` and `req_lsb = (count_lsb != 0)`.
- **Grant.**
  - If only one side is requesting, that side is granted.
  - If both are requesting, the side not recorded in `last_grant` is granted.
- **Output.**
  - `out_valid = rdy_in && !predict_fail && (req_rs || req_lsb)`.
  - `out_tag` and `out_val` are the granted FIFO's head entry, selected combinationally.
  - `out_src` is the granted side.
  - When `out_valid` is 0, `out_tag`, `out_val` and `out_src` are 0.
- **Pop.**
  - On `out_valid && out_ready`, the granted FIFO's `head` advances and `count` decrements.
  - `last_grant` is updated to the granted side.
  - `last_grant` changes only on a pop.
- **Simultaneous push and pop** on the same non-full FIFO: `count` is unchanged, and both pointers advance.
- **Flush.** `predict_fail` with `rdy_in` high clears both FIFOs: counts and pointers go to 0.
  - A push in the flush cycle is discarded.
  - No pop occurs in the flush cycle.
  - `last_grant` resets to LSB.
- **Pause.** With `rdy_in` low, no push, pop or flush takes effect, and all registers hold.
- **Reset.** Reset is asynchronous.
  - Counts and pointers go to 0.
  - `last_grant` goes to LSB, so RS wins the first tie.
  - Reset may arrive mid-transfer; all buffered entries are lost.

## Timing
- **Latency.** A result pushed at edge N is presented on `out_*` during cycle N+1 at the earliest, if its FIFO was empty and it wins arbitration. There is no combinational path from `x_valid` to `out_valid`.
- **Throughput.** One result per cycle in total.
  - With both FIFOs continuously non-empty and `out_ready` high, grants alternate RS, LSB, RS, …
- **Ready paths.** `x_ready` is combinational from `count` and `rdy_in` only.
- **Output paths.** `out_*` is combinational from registers, `rdy_in` and `predict_fail`. `out_ready` does not affect `out_*` within the cycle.
- **Reset values of outputs:**
  - `out_valid` = 0.
  - `out_tag`, `out_val` and `out_src` = 0.
  - `rs_ready` and `lsb_ready` equal `rdy_in`.

## Configuration
- **`WB_ARB_FIXED_PRIO_EN` defined:** the LSB always wins when both sides request, and `last_grant` is unused. This reduces load latency at the cost of possible RS starvation.
- **Undefined (default):** round-robin as above.

## Test plan
- **Single push:** after reset, RS pushes tag 3, value 0xDEADBEEF at edge 1 with `out_ready` = 1.
  - Cycle 2 shows `out_valid` = 1, `out_tag` = 3, `out_val` = 0xDEADBEEF, `out_src` = 0.
  - Cycle 3 shows `out_valid` = 0.
- **Round-robin:** both sides push two entries (RS tags 1, 2; LSB tags 5, 6), then `out_ready` = 1.
  - Output order is tags 1, 5, 2, 6.
  - With `WB_ARB_FIXED_PRIO_EN`, the order is 5, 6, 1, 2.
- **Full and backpressure:** `out_ready` = 0 while RS pushes tags 1, 2, 3 on consecutive edges (DEPTH = 2).
  - `rs_ready` drops after the second push, and tag 3 is held off.
  - Raising `out_ready` pops tag 1, after which `rs_ready` = 1 the next cycle.
- **Flush:** with 2 RS entries and 1 LSB entry buffered, `predict_fail` is pulsed together with an LSB push of tag 7.
  - The next cycle shows `out_valid` = 0, both readies = 1, and tag 7 never appears.
- **Pause:** with entries buffered, `rdy_in` is held low for 3 cycles while `out_ready` = 1 and pushes are requested.
  - `out_valid` = 0 and both readies = 0 throughout.
  - Contents and order are unchanged afterwards.
- **Pointer wrap:** push and pop 5 entries through the RS FIFO with tags 0 through 4.
  - All emerge in order with correct values across pointer wrap.
  - Asserting `rst_in` between edges immediately forces `out_valid` = 0.
